// File: rtl/sw_logic_debounced.sv
// Switch front end: synchronise, debounce, optional toggle latch,
// registered gate LEDs plus press pulse and press counter.
module sw_logic_debounced #(
    parameter int NUM_SW     = 2,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw,
    input  logic              mode,
    output logic [NUM_SW-1:0] sw_db,
    output logic              led_and,
    output logic              led_or,
    output logic              led_xor,
    output logic              led_nand,
    output logic              led_nor,
    output logic              press_pulse,
    output logic [CNT_W-1:0]  press_cnt
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [NUM_SW-1:0] r_s1;
    logic [NUM_SW-1:0] r_s2;
    logic [DW-1:0]     r_cnt [NUM_SW];
    logic [NUM_SW-1:0] r_sw_db;
    logic [NUM_SW-1:0] r_sw_db_d;
    logic [NUM_SW-1:0] r_tog;
    logic              r_and;
    logic              r_or;
    logic              r_xor;
    logic              r_nand;
    logic              r_nor;
    logic              r_pulse;
    logic [CNT_W-1:0]  r_press_cnt;

    logic [NUM_SW-1:0] w_rise;
    logic [NUM_SW-1:0] w_eff;
    logic [CNT_W-1:0]  w_pop;

    // Two-flop synchroniser for the asynchronous switch pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    // Per-bit debounce: accept a new level only after it stays stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw_db <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (r_s2[i] == r_sw_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_sw_db[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Rising edges of the debounced levels
    always_comb begin
        w_rise = r_sw_db & ~r_sw_db_d;
        w_eff  = mode ? r_tog : r_sw_db;
    end

    // Number of bits rising this cycle, for the press counter
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_pop = w_pop + CNT_W'(w_rise[i]);
        end
    end

    // Edge-detect history and toggle latches, kept in both modes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw_db_d <= '0;
            r_tog     <= '0;
        end else begin
            r_sw_db_d <= r_sw_db;
            r_tog     <= r_tog ^ w_rise;
        end
    end

    // Registered gate LEDs; inverted gates also forced low in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_and  <= 1'b0;
            r_or   <= 1'b0;
            r_xor  <= 1'b0;
            r_nand <= 1'b0;
            r_nor  <= 1'b0;
        end else begin
            r_and  <= &w_eff;
            r_or   <= |w_eff;
            r_xor  <= ^w_eff;
            r_nand <= ~&w_eff;
            r_nor  <= ~|w_eff;
        end
    end

    // Single pulse per event cycle and wrapping press count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pulse     <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_pulse     <= |w_rise;
            r_press_cnt <= r_press_cnt + w_pop;
        end
    end

    assign sw_db       = r_sw_db;
    assign led_and     = r_and;
    assign led_or      = r_or;
    assign led_xor     = r_xor;
    assign led_nand    = r_nand;
    assign led_nor     = r_nor;
    assign press_pulse = r_pulse;
    assign press_cnt   = r_press_cnt;

endmodule

// File: tb/tb_sw_logic_debounced.sv
// Bench for sw_logic_debounced: table-driven level vectors with a
// scoreboard queue, plus hand-written bounce/toggle/reset sequences.
module tb_sw_logic_debounced;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic       mode;

    logic [1:0] sw_db;
    logic       led_and, led_or, led_xor, led_nand, led_nor;
    logic       press_pulse;
    logic [7:0] press_cnt;

    logic [1:0] sw_db2;
    logic       and2, or2, xor2, nand2, nor2;
    logic       pulse2;
    logic [1:0] press_cnt2;

    sw_logic_debounced #(.NUM_SW(2), .DEB_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode),
        .sw_db(sw_db), .led_and(led_and), .led_or(led_or),
        .led_xor(led_xor), .led_nand(led_nand), .led_nor(led_nor),
        .press_pulse(press_pulse), .press_cnt(press_cnt)
    );

    sw_logic_debounced #(.NUM_SW(2), .DEB_CYCLES(4), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode),
        .sw_db(sw_db2), .led_and(and2), .led_or(or2),
        .led_xor(xor2), .led_nand(nand2), .led_nor(nor2),
        .press_pulse(pulse2), .press_cnt(press_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [31:0] val;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0] sw;
        logic [4:0] leds;
        logic       pulse;
    } vec_t;
    vec_t vt[4];

    int         m_cnt;
    logic [1:0] m_tog;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(string nm, logic [31:0] val);
        sb_t e;
        e.nm  = nm;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(logic [31:0] act);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got %0h expected entry", act);
        end else begin
            e = sbq.pop_front();
            chk(e.nm, act, e.val);
        end
    endtask

    function automatic logic [4:0] leds_of(logic [1:0] e);
        return {&e, |e, ^e, ~&e, ~|e};
    endfunction

    function automatic logic [31:0] leds_now();
        return 32'({led_and, led_or, led_xor, led_nand, led_nor});
    endfunction

    initial begin
        logic [1:0] prev_sw;
        logic [4:0] prev_leds;
        logic [1:0] r;
        int         npulse;
        int         nrise;
        logic       last0;

        vt[0] = '{sw: 2'b01, leds: 5'b01110, pulse: 1'b1};
        vt[1] = '{sw: 2'b10, leds: 5'b01110, pulse: 1'b1};
        vt[2] = '{sw: 2'b11, leds: 5'b11000, pulse: 1'b1};
        vt[3] = '{sw: 2'b00, leds: 5'b00011, pulse: 1'b0};

        rst_n = 1'b0;
        sw    = 2'b00;
        mode  = 1'b0;
        m_cnt = 0;
        m_tog = 2'b00;

        // reset
        repeat (3) tick();
        chk("rst_sw_db", 32'(sw_db), 32'h0);
        chk("rst_leds", leds_now(), 32'h0);
        chk("rst_pulse", 32'(press_pulse), 32'h0);
        chk("rst_cnt", 32'(press_cnt), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rel_leds", leds_now(), 32'b00011);
        chk("rel_cnt", 32'(press_cnt), 32'h0);

        // level mode vectors
        prev_sw   = 2'b00;
        prev_leds = 5'b00011;
        for (int i = 0; i < 4; i++) begin
            sw    = vt[i].sw;
            r     = vt[i].sw & ~prev_sw;
            m_tog = m_tog ^ r;
            m_cnt = m_cnt + int'(r[0]) + int'(r[1]);
            push("lv_leds", 32'(vt[i].leds));
            push("lv_cnt", 32'(m_cnt & 255));
            push("lv_cnt2", 32'(m_cnt & 3));
            repeat (5) tick();
            chk("lv_db_e5", 32'(sw_db), 32'(prev_sw));
            tick();
            chk("lv_db_e6", 32'(sw_db), 32'(vt[i].sw));
            chk("lv_led_e6", leds_now(), 32'(prev_leds));
            tick();
            chk("lv_pulse_e7", 32'(press_pulse), 32'(vt[i].pulse));
            tick();
            chk("lv_pulse_e8", 32'(press_pulse), 32'h0);
            repeat (12) tick();
            pop_chk(leds_now());
            pop_chk(32'(press_cnt));
            pop_chk(32'(press_cnt2));
            prev_sw   = vt[i].sw;
            prev_leds = vt[i].leds;
        end

        // bounce on sw[0]
        npulse = 0;
        nrise  = 0;
        last0  = sw_db[0];
        sw = 2'b01;
        for (int k = 0; k < 34; k++) begin
            if (k == 2) sw = 2'b00;
            if (k == 4) sw = 2'b01;
            tick();
            if (press_pulse) npulse++;
            if (sw_db[0] && !last0) nrise++;
            last0 = sw_db[0];
        end
        m_cnt++;
        m_tog[0] = ~m_tog[0];
        chk("bnc_rise", 32'(nrise), 32'd1);
        chk("bnc_pulse", 32'(npulse), 32'd1);
        chk("bnc_cnt", 32'(press_cnt), 32'(m_cnt & 255));
        sw = 2'b00;
        repeat (20) tick();
        chk("fall_db", 32'(sw_db), 32'h0);
        chk("fall_cnt", 32'(press_cnt), 32'(m_cnt & 255));

        // short glitch never reaches sw_db
        npulse = 0;
        nrise  = 0;
        sw = 2'b01;
        for (int k = 0; k < 24; k++) begin
            if (k == 3) sw = 2'b00;
            tick();
            if (press_pulse) npulse++;
            if (sw_db[0]) nrise++;
        end
        chk("glitch_db", 32'(nrise), 32'd0);
        chk("glitch_pulse", 32'(npulse), 32'd0);

        // toggle mode
        mode = 1'b1;
        tick();
        chk("tog_enter", leds_now(), 32'(leds_of(m_tog)));
        for (int p = 0; p < 2; p++) begin
            sw = 2'b10;
            m_tog[1] = ~m_tog[1];
            m_cnt++;
            push("tog_leds", 32'(leds_of(m_tog)));
            push("tog_cnt", 32'(m_cnt & 255));
            repeat (20) tick();
            sw = 2'b00;
            repeat (20) tick();
            pop_chk(leds_now());
            pop_chk(32'(press_cnt));
        end
        mode = 1'b0;
        #1;
        chk("mode_hold", leds_now(), 32'(leds_of(m_tog)));
        tick();
        chk("mode_lvl", leds_now(), 32'b00011);
        mode = 1'b1;
        tick();
        chk("tog_kept", leds_now(), 32'(leds_of(m_tog)));
        mode = 1'b0;

        // simultaneous rise
        sw = 2'b11;
        m_cnt = m_cnt + 2;
        repeat (6) tick();
        chk("both_db", 32'(sw_db), 32'h3);
        tick();
        chk("both_pulse", 32'(press_pulse), 32'h1);
        chk("both_cnt", 32'(press_cnt), 32'(m_cnt & 255));
        tick();
        chk("both_pulse_off", 32'(press_pulse), 32'h0);
        chk("both_cnt2", 32'(press_cnt2), 32'(m_cnt & 3));
        sw = 2'b00;
        repeat (20) tick();

        // reset at debounce count 3
        sw = 2'b01;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_db", 32'(sw_db), 32'h0);
        chk("mid_leds", leds_now(), 32'h0);
        chk("mid_cnt", 32'(press_cnt), 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mid_e5", 32'(sw_db), 32'h0);
        tick();
        chk("mid_e6", 32'(sw_db), 32'h1);
        tick();
        chk("mid_pulse", 32'(press_pulse), 32'h1);
        chk("mid_cnt1", 32'(press_cnt), 32'h1);

        // counter wrap on the narrow instance
        rst_n = 1'b0;
        sw = 2'b00;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        for (int p = 0; p < 5; p++) begin
            sw = 2'b01;
            repeat (10) tick();
            sw = 2'b00;
            repeat (10) tick();
        end
        chk("wrap_cnt8", 32'(press_cnt), 32'd5);
        chk("wrap_cnt2", 32'(press_cnt2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
